// File: rtl/echo_fb.sv
// echo_fb: feedback echo stage for the synth audio path.
// One delay line in inferred single-clock RAM with a run-time delay length.
// The scaled delayed sample is fed back into the line, giving repeating,
// decaying echoes. Dry input and wet tap are mixed with independent gains
// and the result is saturated to the sample width.
//
// Strobe protocol (input and output side alike): new_sample_in is a one-cycle
// strobe qualifying sample_in in that same cycle; there is no back-pressure.
// A strobe is accepted when the pipeline is idle; an accepted strobe at cycle
// T occupies the pipeline for T..T+3, and its result appears on sample_out
// with a one-cycle new_sample_out pulse at T+3. A strobe arriving while the
// pipeline is busy is discarded and reported by a one-cycle dropped pulse in
// the following cycle. Sources must therefore space strobes >= 4 cycles apart.
module echo_fb #(
  parameter int W         = 16,
  parameter int DEPTH     = 11,
  parameter int GAIN_W    = 9,
  parameter int GAIN_FRAC = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DEPTH-1:0]    delay_len,
  input  logic [GAIN_W-1:0]   fb_gain,
  input  logic [GAIN_W-1:0]   wet_gain,
  input  logic [GAIN_W-1:0]   dry_gain,
  input  logic                new_sample_in,
  input  logic signed [W-1:0] sample_in,
  output logic signed [W-1:0] sample_out,
  output logic                new_sample_out,
  output logic                dropped,
  output logic [1:0]          dbg_state
);

  // Product width holds a W-bit signed sample times a zero-extended gain;
  // sums are one bit wider so two products can never overflow.
  localparam int PW     = W + GAIN_W + 1;
  localparam int SW     = PW + 1;
  localparam int NWORDS = 1 << DEPTH;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [DEPTH-1:0]     ONE     = DEPTH'(1);

  // IDLE: no echo (disabled or just reset). FILL: the delay line is being
  // refilled since the last (re)start, so the tap is still muted. RUN: the
  // line holds delay_len valid samples and the tap is heard.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DEPTH-1:0]  fill_cnt, fill_nxt;
  logic [DEPTH-1:0]  fill_first;
  logic [DEPTH-1:0]  wptr;
  logic [DEPTH-1:0]  dly_reg;
  logic [DEPTH-1:0]  rd_addr;

  logic              busy;
  logic              accept;
  logic              dly_chg;
  logic              fill_full;
  logic              tap_en;

  // Stage valids: v1 is the cycle after acceptance, v2 the one after that;
  // new_sample_out itself marks the last busy cycle.
  logic              v1, v2;

  // Stage-1 registers (captured with the accepted strobe).
  logic signed [W-1:0] x1;
  logic [GAIN_W-1:0]   fb_g1, wet_g1, dry_g1;
  logic                tap_en1;
  logic                wr_en1;

  // Stage-2 registers (products).
  logic signed [W-1:0]  x2;
  logic                 wr_en2;
  logic signed [PW-1:0] p_fb, p_wet, p_dry;

  // Combinational datapath.
  logic signed [W-1:0]  rd_data;
  logic signed [W-1:0]  tap;
  logic signed [PW-1:0] m_fb, m_wet, m_dry;
  logic signed [SW-1:0] mix_sum, mix_sh;
  logic signed [SW-1:0] fb_sum;

  logic signed [W-1:0]  mem [0:NWORDS-1];

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b0, {(W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return v[W-1:0];
    end
  endfunction

  assign busy      = v1 | v2 | new_sample_out;
  assign accept    = new_sample_in & ~busy;
  assign dly_chg   = (delay_len != dly_reg);
  assign fill_full = (fill_cnt == delay_len);
  // The restarting strobe itself writes one sample into the line.
  assign fill_first = (delay_len != '0) ? ONE : '0;
  // Tap is only heard once delay_len samples have been written since the
  // last restart, so stale RAM contents never reach the output.
  assign tap_en    = enable && (delay_len != '0) && !dly_chg &&
                     ((state == RUN) || ((state == FILL) && fill_full));
  assign rd_addr   = wptr - delay_len;
  assign dbg_state = state;

  // Next-state and fill-count logic.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    if (!enable) begin
      state_nxt = IDLE;
      fill_nxt  = '0;
    end else if ((state != IDLE) && dly_chg) begin
      state_nxt = FILL;
      fill_nxt  = accept ? fill_first : '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          state_nxt = FILL;
          fill_nxt  = fill_first;
        end
        FILL: begin
          if (fill_full) begin
            state_nxt = RUN;
          end else begin
            fill_nxt = fill_cnt + ONE;
          end
        end
        RUN: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = IDLE;
          fill_nxt  = '0;
        end
      endcase
    end
  end

  // State register, fill counter and the delay copy taken at each accepted strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
      dly_reg  <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      if (accept) begin
        dly_reg <= delay_len;
      end
    end
  end

  // Delay-line RAM: synchronous read at acceptance, feedback write two cycles later.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data <= mem[rd_addr];
    end
    if (v2 && wr_en2) begin
      mem[wptr] <= sat(fb_sum);
    end
  end

  assign tap   = tap_en1 ? rd_data : '0;
  assign m_fb  = PW'(tap) * PW'($signed({1'b0, fb_g1}));
  assign m_wet = PW'(tap) * PW'($signed({1'b0, wet_g1}));
  assign m_dry = PW'(x1)  * PW'($signed({1'b0, dry_g1}));

  assign mix_sum = SW'(p_dry) + SW'(p_wet);
  assign mix_sh  = mix_sum >>> GAIN_FRAC;
  assign fb_sum  = SW'(x2) + SW'(p_fb >>> GAIN_FRAC);

  // Three-stage sample pipeline with strobe/valid tracking and drop reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      new_sample_out <= 1'b0;
      dropped        <= 1'b0;
      sample_out     <= '0;
      wptr           <= '0;
      x1             <= '0;
      fb_g1          <= '0;
      wet_g1         <= '0;
      dry_g1         <= '0;
      tap_en1        <= 1'b0;
      wr_en1         <= 1'b0;
      x2             <= '0;
      wr_en2         <= 1'b0;
      p_fb           <= '0;
      p_wet          <= '0;
      p_dry          <= '0;
    end else begin
      v1             <= accept;
      v2             <= v1;
      new_sample_out <= v2;
      dropped        <= new_sample_in & busy;
      if (accept) begin
        x1      <= sample_in;
        fb_g1   <= fb_gain;
        wet_g1  <= wet_gain;
        dry_g1  <= dry_gain;
        tap_en1 <= tap_en;
        wr_en1  <= enable;
      end
      if (v1) begin
        x2     <= x1;
        wr_en2 <= wr_en1;
        p_fb   <= m_fb;
        p_wet  <= m_wet;
        p_dry  <= m_dry;
      end
      if (v2) begin
        sample_out <= sat(mix_sh);
        if (wr_en2) begin
          wptr <= wptr + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_fb.sv
// Bench for echo_fb with a small delay line (DEPTH=4). Directed scenarios
// use expected values worked out by hand; the random scenario compares
// against a reference model that keeps the list of samples written since
// the last echo restart and reads the tap delay_len entries back.
module tb_echo_fb;

  localparam int W         = 16;
  localparam int DEPTH     = 4;
  localparam int GAIN_W    = 9;
  localparam int GAIN_FRAC = 8;

  logic                clk;
  logic                reset_n;
  logic                enable;
  logic [DEPTH-1:0]    delay_len;
  logic [GAIN_W-1:0]   fb_gain;
  logic [GAIN_W-1:0]   wet_gain;
  logic [GAIN_W-1:0]   dry_gain;
  logic                new_sample_in;
  logic signed [W-1:0] sample_in;
  logic signed [W-1:0] sample_out;
  logic                new_sample_out;
  logic                dropped;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: samples written since last restart.
  int hist[$];
  int model_last_dl = 0;
  logic [W-1:0] exp_q[$];

  int imp_exp [13] = '{1000, 0, 0, 1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};

  echo_fb #(
    .W(W), .DEPTH(DEPTH), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .delay_len(delay_len),
    .fb_gain(fb_gain),
    .wet_gain(wet_gain),
    .dry_gain(dry_gain),
    .new_sample_in(new_sample_in),
    .sample_in(sample_in),
    .sample_out(sample_out),
    .new_sample_out(new_sample_out),
    .dropped(dropped),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Model one accepted strobe with the inputs currently applied.
  function automatic int model_strobe(input int x);
    int     dl;
    longint tap;
    longint fg, wg, dg;
    dl  = int'(delay_len);
    fg  = longint'(fb_gain);
    wg  = longint'(wet_gain);
    dg  = longint'(dry_gain);
    tap = 0;
    if (!enable) begin
      hist.delete();
    end else begin
      if (dl != model_last_dl) hist.delete();
      if (dl > 0 && hist.size() >= dl) tap = longint'(hist[hist.size() - dl]);
      hist.push_back(sat16(longint'(x) + ((tap * fg) >>> GAIN_FRAC)));
      if (hist.size() > 64) void'(hist.pop_front());
    end
    model_last_dl = dl;
    return sat16((longint'(x) * dg + tap * wg) >>> GAIN_FRAC);
  endfunction

  // Driver: one strobe, then watch 7 cycles for the output strobe.
  task automatic send(input int x, output logic [W-1:0] y, output int lat, output int cnt);
    @(negedge clk);
    new_sample_in = 1'b1;
    sample_in     = W'(x);
    lat = -1;
    cnt = 0;
    y   = '0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) new_sample_in = 1'b0;
      if (new_sample_out) begin
        cnt++;
        if (lat < 0) begin
          lat = i;
          y   = sample_out;
        end
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hist.delete();
  endtask

  task automatic test_reset();
    logic [W-1:0] y;
    int lat, cnt, seen;
    repeat (3) @(negedge clk);
    n_cmp++; if (sample_out !== '0) begin n_err++; $display("FAIL reset_sample_out got=%0d want=0", sample_out); end
    n_cmp++; if (new_sample_out !== 1'b0) begin n_err++; $display("FAIL reset_nso got=%b want=0", new_sample_out); end
    n_cmp++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped got=%b want=0", dropped); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    reset_n = 1'b1;
    hist.delete();
    model_last_dl = 0;
    enable = 1'b1; delay_len = 4'd15; fb_gain = 9'd0; wet_gain = 9'd0; dry_gain = 9'd256;
    void'(model_strobe(1234));
    send(1234, y, lat, cnt);
    n_cmp++; if (y !== 16'd1234 || lat != 3) begin n_err++; $display("FAIL reset_pre1 got=%0d lat=%0d want=1234 lat=3", $signed(y), lat); end
    void'(model_strobe(4321));
    send(4321, y, lat, cnt);
    n_cmp++; if (y !== 16'd4321 || lat != 3) begin n_err++; $display("FAIL reset_pre2 got=%0d lat=%0d want=4321 lat=3", $signed(y), lat); end
    // Strobe, then assert reset at T+1 while the sample is in flight.
    @(negedge clk);
    new_sample_in = 1'b1;
    sample_in     = 16'd777;
    @(negedge clk);
    new_sample_in = 1'b0;
    reset_n       = 1'b0;
    #1;
    n_cmp++; if (sample_out !== '0) begin n_err++; $display("FAIL midreset_sample_out got=%0d want=0", sample_out); end
    n_cmp++; if (new_sample_out !== 1'b0) begin n_err++; $display("FAIL midreset_nso got=%b want=0", new_sample_out); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      if (new_sample_out) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midreset_no_strobe got=%0d want=0", seen); end
    hist.delete();
    model_last_dl = 0;
    wet_gain = 9'd256; dry_gain = 9'd0;
    void'(model_strobe(999));
    send(999, y, lat, cnt);
    n_cmp++; if (y !== '0 || lat != 3) begin n_err++; $display("FAIL reset_first_tap got=%0d lat=%0d want=0 lat=3", $signed(y), lat); end
  endtask

  task automatic test_impulse();
    logic [W-1:0] y;
    int lat, cnt, x;
    go_idle();
    enable = 1'b1; delay_len = 4'd3; fb_gain = 9'd128; wet_gain = 9'd256; dry_gain = 9'd256;
    for (int k = 0; k < 13; k++) begin
      x = (k == 0) ? 1000 : 0;
      void'(model_strobe(x));
      send(x, y, lat, cnt);
      n_cmp++;
      if (y !== W'(imp_exp[k]) || lat != 3 || cnt != 1) begin
        n_err++;
        $display("FAIL impulse[%0d] got=%0d lat=%0d cnt=%0d want=%0d lat=3 cnt=1", k, $signed(y), lat, cnt, imp_exp[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] y;
    int lat, cnt;
    int xs [2] = '{30000, -30000};
    int e2 [2] = '{32767, -32768};
    for (int p = 0; p < 2; p++) begin
      go_idle();
      enable = 1'b1; delay_len = 4'd1; fb_gain = 9'd0; wet_gain = 9'd256; dry_gain = 9'd256;
      void'(model_strobe(xs[p]));
      send(xs[p], y, lat, cnt);
      n_cmp++; if (y !== W'(xs[p]) || lat != 3) begin n_err++; $display("FAIL sat_first[%0d] got=%0d lat=%0d want=%0d", p, $signed(y), lat, xs[p]); end
      void'(model_strobe(xs[p]));
      send(xs[p], y, lat, cnt);
      n_cmp++; if (y !== W'(e2[p]) || lat != 3) begin n_err++; $display("FAIL sat_clamp[%0d] got=%0d lat=%0d want=%0d", p, $signed(y), lat, e2[p]); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] y;
    int lat, cnt, e;
    go_idle();
    enable = 1'b1; delay_len = 4'd15; fb_gain = 9'd0; wet_gain = 9'd256; dry_gain = 9'd0;
    for (int i = 1; i <= 40; i++) begin
      e = (i <= 15) ? 0 : i - 15;
      void'(model_strobe(i));
      send(i, y, lat, cnt);
      n_cmp++;
      if (y !== W'(e) || lat != 3) begin
        n_err++;
        $display("FAIL wrap[%0d] got=%0d lat=%0d want=%0d lat=3", i, $signed(y), lat, e);
      end
    end
  endtask

  task automatic test_delay_change();
    logic [W-1:0] y;
    int lat, cnt, e;
    int in_v [13];
    go_idle();
    enable = 1'b1; delay_len = 4'd3; fb_gain = 9'd0; wet_gain = 9'd256; dry_gain = 9'd256;
    for (int k = 0; k < 13; k++) in_v[k] = 100 * (k + 1);
    for (int k = 0; k < 13; k++) begin
      if (k == 6) delay_len = 4'd5;
      if (k < 3)       e = in_v[k];
      else if (k < 6)  e = in_v[k] + in_v[k-3];
      else if (k < 11) e = in_v[k];
      else             e = in_v[k] + in_v[k-5];
      void'(model_strobe(in_v[k]));
      send(in_v[k], y, lat, cnt);
      n_cmp++;
      if (y !== W'(e) || lat != 3) begin
        n_err++;
        $display("FAIL delay_change[%0d] got=%0d lat=%0d want=%0d lat=3", k, $signed(y), lat, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] y1, y2;
    int gaps [3] = '{2, 3, 4};
    int g, x1, x2, nso_cnt, drop_cnt, drop_at;
    enable = 1'b1; delay_len = 4'd0; fb_gain = 9'd0; wet_gain = 9'd0; dry_gain = 9'd256;
    for (int t = 0; t < 3; t++) begin
      g  = gaps[t];
      x1 = 100 * g + 1;
      x2 = 100 * g + 2;
      y1 = '0; y2 = '0;
      nso_cnt = 0; drop_cnt = 0; drop_at = -1;
      @(negedge clk);
      new_sample_in = 1'b1;
      sample_in     = W'(x1);
      void'(model_strobe(x1));
      for (int i = 1; i <= 14; i++) begin
        @(negedge clk);
        if (new_sample_out) begin
          if (nso_cnt == 0) y1 = sample_out; else y2 = sample_out;
          nso_cnt++;
        end
        if (dropped) begin
          drop_cnt++;
          if (drop_at < 0) drop_at = i;
        end
        new_sample_in = (i == g);
        if (i == g) begin
          sample_in = W'(x2);
          if (g >= 4) void'(model_strobe(x2));
        end
      end
      n_cmp++; if (nso_cnt != ((g >= 4) ? 2 : 1)) begin n_err++; $display("FAIL overrun_nso gap=%0d got=%0d want=%0d", g, nso_cnt, (g >= 4) ? 2 : 1); end
      n_cmp++; if (drop_cnt != ((g >= 4) ? 0 : 1)) begin n_err++; $display("FAIL overrun_dropped gap=%0d got=%0d want=%0d", g, drop_cnt, (g >= 4) ? 0 : 1); end
      n_cmp++; if (y1 !== W'(x1)) begin n_err++; $display("FAIL overrun_first gap=%0d got=%0d want=%0d", g, $signed(y1), x1); end
      if (g >= 4) begin
        n_cmp++; if (y2 !== W'(x2)) begin n_err++; $display("FAIL overrun_second gap=%0d got=%0d want=%0d", g, $signed(y2), x2); end
      end else begin
        n_cmp++; if (drop_at != g + 1) begin n_err++; $display("FAIL overrun_drop_timing gap=%0d got=%0d want=%0d", g, drop_at, g + 1); end
      end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] y;
    int lat, cnt;
    enable = 1'b0; delay_len = 4'd2; fb_gain = 9'd256; wet_gain = 9'd256; dry_gain = 9'd128;
    void'(model_strobe(1000));
    send(1000, y, lat, cnt);
    n_cmp++; if (y !== 16'd500 || lat != 3 || cnt != 1) begin n_err++; $display("FAIL bypass_half got=%0d lat=%0d cnt=%0d want=500", $signed(y), lat, cnt); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL bypass_state got=%0d want=0", dbg_state); end
    void'(model_strobe(-1001));
    send(-1001, y, lat, cnt);
    n_cmp++; if (y !== W'(-501) || lat != 3) begin n_err++; $display("FAIL bypass_floor got=%0d lat=%0d want=-501", $signed(y), lat); end
    enable = 1'b1; delay_len = 4'd1; fb_gain = 9'd0; wet_gain = 9'd256; dry_gain = 9'd0;
    void'(model_strobe(5));
    send(5, y, lat, cnt);
    n_cmp++; if (y !== '0 || lat != 3) begin n_err++; $display("FAIL reenable_fill got=%0d lat=%0d want=0", $signed(y), lat); end
    void'(model_strobe(6));
    send(6, y, lat, cnt);
    n_cmp++; if (y !== 16'd5 || lat != 3) begin n_err++; $display("FAIL reenable_echo got=%0d lat=%0d want=5", $signed(y), lat); end
  endtask

  task automatic test_random();
    logic [W-1:0] y, e, r;
    int lat, cnt, x;
    go_idle();
    enable = 1'b1; delay_len = 4'd4;
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 7) == 0) delay_len = 4'($urandom_range(0, 15));
      fb_gain  = 9'($urandom_range(0, 511));
      wet_gain = 9'($urandom_range(0, 511));
      dry_gain = 9'($urandom_range(0, 511));
      enable   = ($urandom_range(0, 9) != 0);
      r = 16'($urandom);
      x = int'($signed(r));
      exp_q.push_back(W'(model_strobe(x)));
      send(x, y, lat, cnt);
      e = exp_q.pop_front();
      n_cmp++;
      if (y !== e || lat != 3 || cnt != 1) begin
        n_err++;
        $display("FAIL random[%0d] got=%0d lat=%0d cnt=%0d want=%0d lat=3 cnt=1", it, $signed(y), lat, cnt, $signed(e));
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    delay_len     = '0;
    fb_gain       = '0;
    wet_gain      = '0;
    dry_gain      = '0;
    new_sample_in = 1'b0;
    sample_in     = '0;
    test_reset();
    test_impulse();
    test_saturation();
    test_wrap();
    test_delay_change();
    test_overrun();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
